// File: rtl/gmii_tx_sched.sv
// gmii_tx_sched
// Shares one GMII transmit datapath among NREQ frame sources. Pending
// requests are arbitrated round-robin, the requested length is checked
// (rejected if too long, padded if too short), and a start command with
// the length goes to the transmitter. The grant is held until the
// transmitter reports completion or the watchdog expires, followed by a
// fixed inter-frame gap before the next arbitration.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no frame in flight; arbitrate any pending request each cycle
// XMIT   | grant held, waiting for tx_done; watchdog counting up
// GAP    | inter-frame gap, IFG_CNT cycles, then back to IDLE

module gmii_tx_sched #(
    parameter int NREQ     = 4,
    parameter int LEN_W    = 11,
    parameter int MIN_LEN  = 60,
    parameter int MAX_LEN  = 1514,
    parameter int IFG_CNT  = 12,
    parameter int WDOG_CNT = 4096
) (
    input  logic                    clk_125m,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*LEN_W-1:0]   frm_len,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         rej,
    output logic                    tx_start,
    output logic [LEN_W-1:0]        tx_len,
    input  logic                    tx_done,
    output logic                    tx_abort,
    output logic                    busy,
    output logic [15:0]             frm_cnt,
    output logic [7:0]              abort_cnt
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WD_W  = $clog2(WDOG_CNT);
    localparam int GAP_W = $clog2(IFG_CNT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XMIT = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic [LEN_W-1:0] C_MIN_LEN = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] C_MAX_LEN = LEN_W'(MAX_LEN);
    localparam logic [WD_W-1:0]  C_WD_TC   = WD_W'(WDOG_CNT - 1);
    localparam logic [GAP_W-1:0] C_GAP_LD  = GAP_W'(IFG_CNT - 1);
    localparam logic [IDX_W-1:0] C_PTR_RST = IDX_W'(NREQ - 1);

    logic [1:0]        r_state;
    logic [IDX_W-1:0]  r_ptr;
    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   r_rej;
    logic              r_tx_start;
    logic [LEN_W-1:0]  r_tx_len;
    logic [WD_W-1:0]   r_wdog;
    logic [GAP_W-1:0]  r_gap;
    logic [15:0]       r_frm_cnt;
    logic [7:0]        r_abort_cnt;

    logic [NREQ-1:0]   w_req_eff;
    logic              w_sel_vld;
    logic [IDX_W-1:0]  w_sel_idx;
    logic [LEN_W-1:0]  w_sel_len;
    logic              w_too_long;
    logic [LEN_W-1:0]  w_pad_len;
    logic [NREQ-1:0]   w_onehot;
    logic              w_wd_exp;

    // A source being rejected this cycle still holds req until it sees rej;
    // mask it so it is not rejected a second time.
    assign w_req_eff = req & ~r_rej;

    // Round-robin pick: first pending source scanning upward from ptr+1.
    always_comb begin
        int          idx;
        logic [IDX_W-1:0] cand;
        w_sel_vld = 1'b0;
        w_sel_idx = '0;
        idx       = 0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx  = (int'(r_ptr) + k) % NREQ;
            cand = IDX_W'(idx);
            if (!w_sel_vld && w_req_eff[cand]) begin
                w_sel_vld = 1'b1;
                w_sel_idx = cand;
            end
        end
    end

    assign w_sel_len  = frm_len[w_sel_idx*LEN_W +: LEN_W];
    assign w_too_long = (w_sel_len > C_MAX_LEN);
    assign w_pad_len  = (w_sel_len < C_MIN_LEN) ? C_MIN_LEN : w_sel_len;
    assign w_onehot   = NREQ'(1) << w_sel_idx;

    // Watchdog terminal count; tx_done in the same cycle takes precedence.
    assign w_wd_exp   = (r_state == S_XMIT) && (r_wdog == C_WD_TC);

    // Main sequencer: arbitration, frame hold, watchdog, gap and counters.
    always_ff @(posedge clk_125m or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= C_PTR_RST;
            r_gnt       <= '0;
            r_rej       <= '0;
            r_tx_start  <= 1'b0;
            r_tx_len    <= '0;
            r_wdog      <= '0;
            r_gap       <= '0;
            r_frm_cnt   <= '0;
            r_abort_cnt <= '0;
        end else begin
            r_rej      <= '0;
            r_tx_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_sel_vld) begin
                        r_ptr <= w_sel_idx;
                        if (w_too_long) begin
                            r_rej <= w_onehot;
                        end else begin
                            r_gnt      <= w_onehot;
                            r_tx_start <= 1'b1;
                            r_tx_len   <= w_pad_len;
                            r_wdog     <= '0;
                            r_state    <= S_XMIT;
                        end
                    end
                end
                S_XMIT: begin
                    if (tx_done || w_wd_exp) begin
                        if (tx_done) begin
                            r_frm_cnt <= r_frm_cnt + 16'd1;
                        end else if (r_abort_cnt != 8'hFF) begin
                            r_abort_cnt <= r_abort_cnt + 8'd1;
                        end
                        r_gnt    <= '0;
                        r_tx_len <= '0;
                        r_gap    <= C_GAP_LD;
                        r_state  <= S_GAP;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_gap == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign rej       = r_rej;
    assign tx_start  = r_tx_start;
    assign tx_len    = r_tx_len;
    assign tx_abort  = w_wd_exp & ~tx_done;
    assign busy      = (r_state != S_IDLE);
    assign frm_cnt   = r_frm_cnt;
    assign abort_cnt = r_abort_cnt;

endmodule

// File: tb/tb_gmii_tx_sched.sv
// Directed bench for gmii_tx_sched with default parameters.
module tb_gmii_tx_sched;

    localparam int NREQ  = 4;
    localparam int LEN_W = 11;

    logic                  clk_125m = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*LEN_W-1:0] frm_len;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       rej;
    logic                  tx_start;
    logic [LEN_W-1:0]      tx_len;
    logic                  tx_done;
    logic                  tx_abort;
    logic                  busy;
    logic [15:0]           frm_cnt;
    logic [7:0]            abort_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int exp_src [5] = '{0, 1, 2, 3, 0};
    int exp_len [5] = '{64, 100, 500, 1514, 64};

    always #4 clk_125m = ~clk_125m;

    gmii_tx_sched dut (
        .clk_125m  (clk_125m),
        .rst       (rst),
        .req       (req),
        .frm_len   (frm_len),
        .gnt       (gnt),
        .rej       (rej),
        .tx_start  (tx_start),
        .tx_len    (tx_len),
        .tx_done   (tx_done),
        .tx_abort  (tx_abort),
        .busy      (busy),
        .frm_cnt   (frm_cnt),
        .abort_cnt (abort_cnt)
    );

    task automatic next();
        @(posedge clk_125m);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_len(input int i, input int v);
        frm_len[i*LEN_W +: LEN_W] = LEN_W'(v);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            next();
            n++;
        end
        chk(tag, busy, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int n_ab;
        int last_start;

        rst     = 1'b1;
        req     = '0;
        frm_len = '0;
        tx_done = 1'b0;
        repeat (2) @(posedge clk_125m);
        #1;

        // reset state
        chk("rst_gnt", gnt, 0);
        chk("rst_rej", rej, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_abort", tx_abort, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_len", tx_len, 0);
        chk("rst_frm_cnt", frm_cnt, 0);
        chk("rst_abort_cnt", abort_cnt, 0);
        rst = 1'b0;

        // tx_done in IDLE ignored
        next();
        tx_done = 1'b1;
        next();
        tx_done = 1'b0;
        chk("idle_done_ignored", frm_cnt, 0);
        chk("idle_done_busy", busy, 0);

        // single frame from source 0
        set_len(0, 100);
        req = 4'b0001;
        next();
        chk("t1_gnt", gnt, 4'b0001);
        chk("t1_tx_start", tx_start, 1);
        chk("t1_tx_len", tx_len, 100);
        chk("t1_busy", busy, 1);
        req = '0;
        next();
        chk("t1_start_pulse", tx_start, 0);
        chk("t1_gnt_hold", gnt, 4'b0001);
        repeat (119) next();
        tx_done = 1'b1;
        next();
        tx_done = 1'b0;
        chk("t1_frm_cnt", frm_cnt, 1);
        chk("t1_gnt_drop", gnt, 0);
        chk("t1_len_clr", tx_len, 0);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            next();
        end
        chk("t1_gap_cycles", n, 12);

        // padding of short frame
        set_len(2, 20);
        req = 4'b0100;
        next();
        chk("t2_gnt", gnt, 4'b0100);
        chk("t2_tx_len", tx_len, 60);
        chk("t2_tx_start", tx_start, 1);
        req = '0;
        next();
        tx_done = 1'b1;
        next();
        tx_done = 1'b0;
        chk("t2_frm_cnt", frm_cnt, 2);
        wait_idle("t2_idle");

        // reject oversize, then source 3 on the following arbitration
        set_len(1, 1600);
        req = 4'b0010;
        next();
        chk("t3_rej", rej, 4'b0010);
        chk("t3_no_gnt", gnt, 0);
        chk("t3_no_start", tx_start, 0);
        chk("t3_idle", busy, 0);
        set_len(3, 200);
        req = 4'b1010;
        next();
        chk("t3_gnt3", gnt, 4'b1000);
        chk("t3_rej_once", rej, 0);
        chk("t3_start3", tx_start, 1);
        chk("t3_len3", tx_len, 200);
        req = '0;
        next();
        tx_done = 1'b1;
        next();
        tx_done = 1'b0;
        chk("t3_frm_cnt", frm_cnt, 3);
        wait_idle("t3_idle_end");

        // round-robin fairness with all requests held
        set_len(0, 64);
        set_len(1, 100);
        set_len(2, 500);
        set_len(3, 1514);
        req = 4'b1111;
        last_start = 0;
        for (int f = 0; f < 5; f++) begin
            n = 0;
            while (tx_start !== 1'b1 && n < 100) begin
                next();
                n++;
            end
            chk("rr_start_seen", tx_start, 1);
            chk("rr_gnt", gnt, 32'(1) << exp_src[f]);
            chk("rr_len", tx_len, exp_len[f]);
            if (f > 0) chk("rr_spacing", 32'((cyc - last_start) >= 23), 1);
            last_start = cyc;
            repeat (10) next();
            tx_done = 1'b1;
            next();
            tx_done = 1'b0;
        end
        req = '0;
        wait_idle("rr_idle");
        chk("rr_frm_cnt", frm_cnt, 8);

        // watchdog expiry
        set_len(0, 100);
        req = 4'b0001;
        next();
        chk("wd_start", tx_start, 1);
        req = '0;
        n_ab = 0;
        repeat (4094) begin
            next();
            if (tx_abort === 1'b1) n_ab++;
        end
        chk("wd_no_early_abort", n_ab, 0);
        next();
        chk("wd_abort", tx_abort, 1);
        next();
        chk("wd_abort_pulse", tx_abort, 0);
        chk("wd_abort_cnt", abort_cnt, 1);
        chk("wd_frm_cnt", frm_cnt, 8);
        chk("wd_gnt_drop", gnt, 0);
        chk("wd_busy_gap", busy, 1);
        wait_idle("wd_idle");

        // tx_done on the expiry cycle wins
        req = 4'b0001;
        next();
        chk("coll_start", tx_start, 1);
        req = '0;
        repeat (4095) next();
        tx_done = 1'b1;
        #1;
        chk("coll_no_abort", tx_abort, 0);
        next();
        tx_done = 1'b0;
        chk("coll_frm_cnt", frm_cnt, 9);
        chk("coll_abort_cnt", abort_cnt, 1);
        chk("coll_gnt_drop", gnt, 0);
        wait_idle("coll_idle");

        // async reset in the middle of a frame
        set_len(2, 100);
        req = 4'b0100;
        next();
        chk("rst_mid_gnt", gnt, 4'b0100);
        req = '0;
        repeat (50) next();
        rst = 1'b1;
        #1;
        chk("rst_mid_gnt_drop", gnt, 0);
        chk("rst_mid_no_abort", tx_abort, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_frm_cnt", frm_cnt, 0);
        chk("rst_mid_abort_cnt", abort_cnt, 0);
        next();
        chk("rst_hold_no_abort", tx_abort, 0);
        rst = 1'b0;
        set_len(0, 100);
        set_len(3, 100);
        req = 4'b1001;
        next();
        chk("post_rst_gnt0", gnt, 4'b0001);
        chk("post_rst_start", tx_start, 1);
        req = '0;
        next();
        tx_done = 1'b1;
        next();
        tx_done = 1'b0;
        chk("post_rst_frm_cnt", frm_cnt, 1);
        wait_idle("post_rst_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
